// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Timeout limits are counted in UART bit periods.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int TX_TIMEOUT_BITS   = 12;
    localparam int HOLD_TIMEOUT_BITS = 16;
    localparam int CPB_W             = 13;
    localparam int TICK_W            = 5;

    // A programmed bit period of zero behaves like a period of one cycle.
    function automatic logic [CPB_W-1:0] bit_period_m1(input logic [CPB_W-1:0] cpb);
        return (cpb == '0) ? '0 : cpb - 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting index after last_grant, wrapping modulo NUM_REQ.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               any
);

    logic [IDW:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overrides.
    always_comb begin
        winner = last_grant;
        any    = 1'b0;
        idx    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = {1'b0, last_grant} + (IDW+1)'(off);
            if (idx >= (IDW+1)'(NUM_REQ)) begin
                idx = idx - (IDW+1)'(NUM_REQ);
            end
            if (req[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ character sources: round-robin between
// bursts, owner keeps the line inside a burst, bit-period based timeouts.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// SEND  | single cycle; accept one character from the owner
// WAIT  | character in flight; waiting for tx_done
// HOLD  | burst still open; owner keeps the line for its next character
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 8,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CPB_W-1:0]          clks_per_bit,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic [IDW-1:0]            grant_id,
    output logic                      active,
    input  logic                      err_clr,
    output logic                      timeout_err
);

    state_t             state;
    logic [IDW-1:0]     last_grant;
    logic               last_flag;
    logic [CPB_W-1:0]   bit_cnt;
    logic [TICK_W-1:0]  tick_left;
    logic [CPB_W-1:0]   period_m1;
    logic               tick;
    logic               expired;
    logic [IDW-1:0]     arb_winner;
    logic               arb_any;
    logic               sel_valid;
    logic [DATA_W-1:0]  slice [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (arb_winner),
        .any        (arb_any)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            slice[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign sel_valid = req_valid[grant_id];
    assign period_m1 = bit_period_m1(clks_per_bit);
    assign tick      = (bit_cnt == '0);
    assign expired   = tick && (tick_left == '0);
    assign active    = (state != IDLE);

    // The accept strobe must coincide with the owner's valid, so it is decoded live in SEND.
    always_comb begin
        req_ready = '0;
        if (state == SEND && sel_valid) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_grant  <= IDW'(NUM_REQ - 1);
            last_flag   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            timeout_err <= 1'b0;
            bit_cnt     <= '0;
            tick_left   <= '0;
        end else begin
            tx_start <= 1'b0;
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            // Down-counters: bit_cnt spans one bit period, tick_left counts remaining periods.
            if (tick) begin
                bit_cnt <= period_m1;
                if (tick_left != '0) begin
                    tick_left <= tick_left - 1'b1;
                end
            end else begin
                bit_cnt <= bit_cnt - 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant_id <= arb_winner;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    if (sel_valid) begin
                        tx_start  <= 1'b1;
                        tx_data   <= slice[grant_id];
                        last_flag <= req_last[grant_id];
                        bit_cnt   <= period_m1;
                        tick_left <= TICK_W'(TX_TIMEOUT_BITS - 1);
                        state     <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end

                WAIT: begin
                    if (tx_done) begin
                        if (last_flag) begin
                            last_grant <= grant_id;
                            state      <= IDLE;
                        end else begin
                            bit_cnt   <= period_m1;
                            tick_left <= TICK_W'(HOLD_TIMEOUT_BITS - 1);
                            state     <= HOLD;
                        end
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        last_grant  <= grant_id;
                        state       <= IDLE;
                    end
                end

                HOLD: begin
                    if (sel_valid) begin
                        state <= SEND;
                    end else if (expired) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8: character width.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clks_per_bit  input  13  UART bit period in clk cycles; used only for timeouts; value 0 treated as 1.
REQ-006 req_valid  input  NUM_REQ  per-requester character-valid.
REQ-007 req_data  input  NUM_REQ*DATA_W  per-requester character; slice i at [i*DATA_W +: DATA_W].
REQ-008 req_last  input  NUM_REQ  per-requester "last character of burst" qualifier.
REQ-009 req_ready  output  NUM_REQ  one-hot accept strobe to the granted requester.
REQ-010 tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_data  output  DATA_W  character to transmit, valid while tx_start=1.
REQ-012 tx_done  input  1  one-cycle pulse from the transmitter after the stop bit.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the current owner.
REQ-014 active  output  1  high in any state other than IDLE.
REQ-015 err_clr  input  1  clears timeout_err.
REQ-016 timeout_err  output  1  sticky: transmitter failed to return tx_done in time.

Function
REQ-017 FSM states SHALL be IDLE, SEND, WAIT, HOLD.
REQ-018 IDLE: if any req_valid=1, winner = first set bit scanning round-robin from (last_grant+1) mod NUM_REQ; grant_id registered; next state SEND (1-cycle arbitration latency).
REQ-019 SEND (exactly one cycle): if req_valid[grant_id]=1 -> tx_start=1, tx_data=req_data slice, req_ready[grant_id]=1, last flag captured from req_last[grant_id], next WAIT; else no outputs asserted, next IDLE.
REQ-020 A character SHALL be accepted only on a cycle with req_valid[i]=1 and req_ready[i]=1; req_ready SHALL never assert outside SEND nor to more than one requester.
REQ-021 WAIT: on tx_done=1 -> if last flag=1 go IDLE and set last_grant=grant_id, else go HOLD; tx_done outside WAIT SHALL be ignored.
REQ-022 HOLD: requester grant_id owns the line; other req_valid ignored; when req_valid[grant_id]=1 -> SEND next cycle (no re-arbitration).
REQ-023 Timeout counter: bit tick every max(clks_per_bit,1) cycles, counter cleared on each state entry.
REQ-024 WAIT with 12 ticks and no tx_done -> timeout_err=1, last_grant=grant_id, next IDLE.
REQ-025 HOLD with 16 ticks and no req_valid[grant_id] -> release: last_grant=grant_id, next IDLE, no error.
REQ-026 tx_done and the 12th tick in the same cycle: tx_done wins, no error.
REQ-027 err_clr and a new timeout in the same cycle: timeout_err=1 (set wins).
REQ-028 A single requester asserting continuously with req_last=1 each character SHALL still yield to any other valid requester at the next arbitration (fairness: at most one burst per requester per round).

Reset
REQ-029 rst_n=0 at a clock edge SHALL force: state IDLE, req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, timeout_err=0, counters 0, last_grant=NUM_REQ-1 (requester 0 wins first).
REQ-030 Reset asserted mid-burst SHALL abandon the burst without any further tx_start; a later tx_done SHALL be ignored.

Structure
REQ-031 Shared package uart_sched_pkg SHALL hold the state enum, TX_TIMEOUT_BITS=12, HOLD_TIMEOUT_BITS=16.
REQ-032 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, last_grant; outputs winner index, any).
REQ-033 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path except tx_data/req_ready qualified by state.

Verification
REQ-034 Req 0 valid, data 0x41, last=1; tx_done 20 cycles after start -> tx_start at cycle 2, tx_data=0x41, req_ready=0001, back to IDLE, active=0.
REQ-035 Req 1 and 3 valid together from reset -> grants 1 then 3, then 1 again if still valid; never two req_ready bits.
REQ-036 Req 2 burst 0x10,0x11,0x12 (last on 0x12) while req 0 valid -> three req 2 characters back-to-back, then req 0.
REQ-037 clks_per_bit=4, tx_done never returned -> timeout_err=1 at 48 cycles after WAIT entry, state IDLE; err_clr pulse -> 0.
REQ-038 Req 1 burst, last=0, then req_valid drops; clks_per_bit=4 -> release after 64 cycles in HOLD, timeout_err stays 0, req 0 granted next.
REQ-039 rst_n=0 during WAIT, then tx_done pulse after reset -> no tx_start, all outputs at reset values.
